tetris_key_cmd: RTL and testbench

TETRIS_KEY_CMD -- requirements
Module: tetris_key_cmd

---
 rtl/tetris_pkg.sv | 52 +++++
 rtl/tetris_cmd_fifo.sv | 69 ++++++
 rtl/tetris_key_cmd.sv | 193 +++++++++++++++++++
 tb/tb_tetris_key_cmd.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared command encodings, PS/2 scan codes and key FSM states for the Tetris key front end.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_SOFT_DOWN = 3'd3,
    CMD_HARD_DROP = 3'd4,
    CMD_ROT_CW    = 3'd5,
    CMD_ROT_CCW   = 3'd6
  } cmd_e;

  localparam logic [7:0] SC_LEFT      = 8'h6B;
  localparam logic [7:0] SC_RIGHT     = 8'h74;
  localparam logic [7:0] SC_SOFT_DOWN = 8'h72;
  localparam logic [7:0] SC_HARD_DROP = 8'h75;
  localparam logic [7:0] SC_ROT_CW    = 8'h22;
  localparam logic [7:0] SC_ROT_CCW   = 8'h1A;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_HELD   = 2'd1,
    KS_REPEAT = 2'd2
  } key_state_e;

  localparam int unsigned CNT_W = 10;

  function automatic cmd_e dec_move(input logic [7:0] code);
    case (code)
      SC_LEFT:      dec_move = CMD_LEFT;
      SC_RIGHT:     dec_move = CMD_RIGHT;
      SC_SOFT_DOWN: dec_move = CMD_SOFT_DOWN;
      SC_HARD_DROP: dec_move = CMD_HARD_DROP;
      default:      dec_move = CMD_NONE;
    endcase
  endfunction

  function automatic cmd_e dec_rot(input logic [7:0] code);
    case (code)
      SC_ROT_CW:  dec_rot = CMD_ROT_CW;
      SC_ROT_CCW: dec_rot = CMD_ROT_CCW;
      default:    dec_rot = CMD_NONE;
    endcase
  endfunction

  // Only lateral moves and soft drop auto-repeat.
  function automatic logic is_repeatable(input cmd_e c);
    is_repeatable = (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_SOFT_DOWN);
  endfunction

endpackage

// File: rtl/tetris_cmd_fifo.sv
// Command queue: DEPTH entries (power of two) of 3-bit commands, valid/ready read side.
module tetris_cmd_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       rd_valid,
  output logic [2:0] rd_data,
  input  logic       rd_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [2:0]       mem_q [DEPTH];
  logic [2:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign rd_valid = !empty;
  assign rd_data  = mem_q[rd_ptr_q];

  // A write into a full queue is accepted when the head is popped in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_rd    = rd_valid && rd_ready;
    do_wr    = wr_en && (!full || do_rd);
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tetris_key_cmd.sv
// PS/2 key state to game command translator with queued output.
// TETRIS_KEY_AUTOREPEAT_EN compiles in delayed auto-repeat for the movement key.
module tetris_key_cmd
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_MS     = 170,
  parameter int unsigned ARR_MS     = 50,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       key1_on,
  input  logic [7:0] key1_code,
  input  logic       key2_on,
  input  logic [7:0] key2_code,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready,
  output logic       overflow
);

  logic       k1_on_q, k1_on_d;
  logic [7:0] k1_code_q, k1_code_d;
  logic       k2_on_q, k2_on_d;
  logic [7:0] k2_code_q, k2_code_d;
  key_state_e state_q, state_d;
  logic       pend_vld_q, pend_vld_d;
  cmd_e       pend_cmd_q, pend_cmd_d;
  logic       ovf_q, ovf_d;

  cmd_e       dec1, dec2, k1_cmd;
  logic       press1, press2v, k1_emit, drop2;
  logic       wr_en;
  logic [2:0] wr_data;
  logic       fifo_full, unused_fifo_empty;

`ifdef TETRIS_KEY_AUTOREPEAT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_e             cmd1_q, cmd1_d;
`else
  localparam int unsigned unused_timing = DAS_MS + ARR_MS;
  logic unused_tick;
  assign unused_tick = tick_ms;
`endif

  always_comb begin
    k1_on_d    = key1_on;
    k1_code_d  = key1_code;
    k2_on_d    = key2_on;
    k2_code_d  = key2_code;
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_cmd_d = pend_cmd_q;
    ovf_d      = ovf_q;
    k1_emit    = 1'b0;
    k1_cmd     = CMD_NONE;
    drop2      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = CMD_NONE;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
    cnt_d      = cnt_q;
    cmd1_d     = cmd1_q;
`endif
    dec1    = dec_move(key1_code);
    dec2    = dec_rot(key2_code);
    press1  = key1_on && (!k1_on_q || (key1_code != k1_code_q));
    press2v = key2_on && (!k2_on_q || (key2_code != k2_code_q)) && (dec2 != CMD_NONE);

    // Movement key FSM: a press (edge or code change) always restarts from the hold phase.
    if (!key1_on) begin
      state_d = KS_IDLE;
    end else if (press1) begin
      if (dec1 != CMD_NONE) begin
        state_d = KS_HELD;
        k1_emit = 1'b1;
        k1_cmd  = dec1;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
        cnt_d   = '0;
        cmd1_d  = dec1;
`endif
      end else begin
        state_d = KS_IDLE;
      end
    end else begin
`ifdef TETRIS_KEY_AUTOREPEAT_EN
      case (state_q)
        KS_HELD: begin
          if (tick_ms) begin
            if ((cnt_q == CNT_W'(DAS_MS - 1)) && is_repeatable(cmd1_q)) begin
              state_d = KS_REPEAT;
              cnt_d   = '0;
              k1_emit = 1'b1;
              k1_cmd  = cmd1_q;
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        KS_REPEAT: begin
          if (tick_ms) begin
            if (cnt_q == CNT_W'(ARR_MS - 1)) begin
              cnt_d   = '0;
              k1_emit = 1'b1;
              k1_cmd  = cmd1_q;
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = state_q;
      endcase
`endif
    end

    // One FIFO write per cycle: key1 first, then the parked key2 command, then a fresh key2.
    if (k1_emit) begin
      wr_en   = 1'b1;
      wr_data = k1_cmd;
      if (press2v) begin
        if (pend_vld_q) begin
          drop2 = 1'b1;
        end else begin
          pend_vld_d = 1'b1;
          pend_cmd_d = dec2;
        end
      end
    end else if (pend_vld_q) begin
      wr_en   = 1'b1;
      wr_data = pend_cmd_q;
      if (press2v) begin
        pend_cmd_d = dec2;
      end else begin
        pend_vld_d = 1'b0;
      end
    end else if (press2v) begin
      wr_en   = 1'b1;
      wr_data = dec2;
    end

    if (drop2 || (wr_en && fifo_full && !(cmd_valid && cmd_ready))) begin
      ovf_d = 1'b1;
    end
  end

  // Reset reloads key history from the live inputs so a held key is not seen as a new press.
  always_ff @(posedge clk) begin
    if (rst) begin
      k1_on_q    <= key1_on;
      k1_code_q  <= key1_code;
      k2_on_q    <= key2_on;
      k2_code_q  <= key2_code;
      state_q    <= KS_IDLE;
      pend_vld_q <= 1'b0;
      pend_cmd_q <= CMD_NONE;
      ovf_q      <= 1'b0;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
      cnt_q      <= '0;
      cmd1_q     <= CMD_NONE;
`endif
    end else begin
      k1_on_q    <= k1_on_d;
      k1_code_q  <= k1_code_d;
      k2_on_q    <= k2_on_d;
      k2_code_q  <= k2_code_d;
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_cmd_q <= pend_cmd_d;
      ovf_q      <= ovf_d;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
      cnt_q      <= cnt_d;
      cmd1_q     <= cmd1_d;
`endif
    end
  end

  assign overflow = ovf_q;

  tetris_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (fifo_full),
    .empty    (unused_fifo_empty),
    .rd_valid (cmd_valid),
    .rd_data  (cmd),
    .rd_ready (cmd_ready)
  );

endmodule

// File: tb/tb_tetris_key_cmd.sv
// Directed scoreboard bench for tetris_key_cmd; 1 ms is compressed to 4 clock cycles.
module tb_tetris_key_cmd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_ms = 1'b0;
  logic       key1_on = 1'b0;
  logic [7:0] key1_code = 8'h00;
  logic       key2_on = 1'b0;
  logic [7:0] key2_code = 8'h00;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       overflow;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_pop = 0;
  int         cyc = 0;
  int         tick_div = 0;
  int         p0;
  int         gap;
  logic [2:0] sb [$];
  int         pop_cyc [$];
  logic [2:0] mon_exp;
  logic [7:0] s4_code [6];
  logic [2:0] s4_cmd [4];

  tetris_key_cmd dut (
    .clk       (clk),
    .rst       (rst),
    .tick_ms   (tick_ms),
    .key1_on   (key1_on),
    .key1_code (key1_code),
    .key2_on   (key2_on),
    .key2_code (key2_code),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      tick_ms  = (tick_div == 3);
      tick_div = (tick_div + 1) % 4;
    end
  end

  // Every handshake pops the scoreboard; a pop with nothing expected is an error.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        n_vec++;
        n_pop++;
        pop_cyc.push_back(cyc);
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL pop_unexpected got=%0d want=none", cmd);
        end
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          assert (cmd === mon_exp) else begin
            n_err++;
            $error("FAIL pop_order got=%0d want=%0d", cmd, mon_exp);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_vec++;
    assert (got == want) else begin
      n_err++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic wait_ms(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  initial begin
    s4_code = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h22, 8'h1A};
    s4_cmd  = '{3'd1, 3'd2, 3'd3, 3'd4};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_valid", {2'b00, cmd_valid}, 3'd0);
    check("rst_cmd", cmd, 3'd0);
    check("rst_overflow", {2'b00, overflow}, 3'd0);

    // Short LEFT hold: one command only
    p0 = n_pop;
    @(negedge clk);
    key1_code = 8'h6B; key1_on = 1'b1; sb.push_back(3'd1);
    wait_ms(100);
    @(negedge clk); key1_on = 1'b0;
    repeat (8) @(negedge clk);
    check_int("s1_left_count", n_pop - p0, 1);
    check_int("s1_sb_empty", sb.size(), 0);

`ifdef TETRIS_KEY_AUTOREPEAT_EN
    // RIGHT held 300 ms: press, 170 ms, 220 ms, 270 ms
    p0 = n_pop;
    @(negedge clk);
    key1_code = 8'h74; key1_on = 1'b1;
    repeat (4) sb.push_back(3'd2);
    wait_ms(300);
    @(negedge clk); key1_on = 1'b0;
    repeat (8) @(negedge clk);
    check_int("s2_right_count", n_pop - p0, 4);
    check_int("s2_sb_empty", sb.size(), 0);
`else
    // LEFT held 500 ms with no auto-repeat
    p0 = n_pop;
    @(negedge clk);
    key1_code = 8'h6B; key1_on = 1'b1; sb.push_back(3'd1);
    wait_ms(500);
    @(negedge clk); key1_on = 1'b0;
    repeat (8) @(negedge clk);
    check_int("s6_left_count", n_pop - p0, 1);
    check_int("s6_sb_empty", sb.size(), 0);
`endif

    // Simultaneous key1/key2 presses: key1 first, key2 next cycle
    p0 = n_pop;
    pop_cyc.delete();
    @(negedge clk);
    key1_code = 8'h72; key1_on = 1'b1;
    key2_code = 8'h22; key2_on = 1'b1;
    sb.push_back(3'd3); sb.push_back(3'd5);
    repeat (10) @(negedge clk);
    key1_on = 1'b0; key2_on = 1'b0;
    repeat (4) @(negedge clk);
    check_int("s3_count", n_pop - p0, 2);
    gap = (pop_cyc.size() >= 2) ? (pop_cyc[1] - pop_cyc[0]) : -1;
    check_int("s3_consecutive", gap, 1);

    // Stalled consumer, six presses: four kept, overflow set, head stable
    p0 = n_pop;
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        key1_code = s4_code[i]; key1_on = 1'b1; sb.push_back(s4_cmd[i]);
      end else begin
        key2_code = s4_code[i]; key2_on = 1'b1;
      end
      repeat (3) @(negedge clk);
      key1_on = 1'b0; key2_on = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("s4_head_stable", cmd, 3'd1);
    end
    check("s4_overflow", {2'b00, overflow}, 3'd1);
    check("s4_valid", {2'b00, cmd_valid}, 3'd1);
    @(negedge clk); cmd_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_int("s4_drain_count", n_pop - p0, 4);
    check_int("s4_sb_empty", sb.size(), 0);

    // Reset with two entries queued and key1 still held
    cmd_ready = 1'b0;
    p0 = n_pop;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
    @(negedge clk);
    key1_code = 8'h74; key1_on = 1'b1;
    wait_ms(185);
`else
    @(negedge clk);
    key2_code = 8'h22; key2_on = 1'b1;
    repeat (3) @(negedge clk);
    key2_on = 1'b0;
    @(negedge clk);
    key1_code = 8'h74; key1_on = 1'b1;
    wait_ms(20);
`endif
    #1;
    check("s5_pre_valid", {2'b00, cmd_valid}, 3'd1);
    check("s5_pre_overflow", {2'b00, overflow}, 3'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check("s5_rst_valid", {2'b00, cmd_valid}, 3'd0);
    check("s5_rst_overflow", {2'b00, overflow}, 3'd0);
    check("s5_rst_cmd", cmd, 3'd0);
    @(negedge clk); cmd_ready = 1'b1;
    wait_ms(250);
    check_int("s5_held_silent", n_pop - p0, 0);
    @(negedge clk); key1_on = 1'b0;
    repeat (4) @(negedge clk);
    key1_on = 1'b1; sb.push_back(3'd2);
    repeat (8) @(negedge clk);
    key1_on = 1'b0;
    repeat (8) @(negedge clk);
    check_int("s5_repress_count", n_pop - p0, 1);
    check_int("s5_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
